vect_mem_sequencer: RTL

- Multi-cycle controller for the vector ASIP memory stage.
- Serialises a vector load or store (vectorSize lanes of registerSize bits) into one memory access per lane, on a registerSize-wide data memory port.
- Holds the pipe_vect stage registers via `stall` for the whole transfer.
- Presents the assembled load vector on `vect_out`, qualified by a one-cycle `done` pulse.

---
 rtl/vect_mem_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vect_mem_sequencer.sv
// vect_mem_sequencer
//   Memory-stage controller for the vector ASIP. A vector load or store of
//   vectorSize lanes is serialised into one registerSize-wide memory access
//   per lane. The upstream pipe registers are frozen with `stall` for the
//   whole transfer. A load's result appears on `vect_out` and is qualified
//   by a one-cycle `done` pulse.
//
// Ports
//   clk, reset           clock (rising edge); asynchronous active-low reset
//   start, op_load       request / 1=load 0=store (sampled in IDLE or DONE)
//   base_addr, vect_in   lane-0 word address and store data (sampled with start)
//   mem_ready, mem_rdata memory handshake and read data
//   mem_req, mem_we      access request / write enable
//   mem_addr, mem_wdata  access address / write data
//   vect_out             assembled load vector
//   stall, done          upstream hold / completion pulse

// Holds one lane of the assembled load vector.
module vect_mem_lane #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] lane_out
);
  logic [W-1:0] lane_q, lane_d;

  always_comb begin
    lane_d = lane_q;
    if (wr_en) lane_d = wdata;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) lane_q <= '0;
    else        lane_q <= lane_d;

  assign lane_out = lane_q;
endmodule

module vect_mem_sequencer #(
  parameter int registerSize = 16,
  parameter int vectorSize   = 4,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     op_load,
  input  logic [ADDR_WIDTH-1:0]                    base_addr,
  input  logic [vectorSize-1:0][registerSize-1:0]  vect_in,
  input  logic                                     mem_ready,
  input  logic [registerSize-1:0]                  mem_rdata,
  output logic                                     mem_req,
  output logic                                     mem_we,
  output logic [ADDR_WIDTH-1:0]                    mem_addr,
  output logic [registerSize-1:0]                  mem_wdata,
  output logic [vectorSize-1:0][registerSize-1:0]  vect_out,
  output logic                                     stall,
  output logic                                     done
);
  localparam int LANE_W = $clog2(vectorSize);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_e;

  state_e                                  state_q, state_d;
  logic [LANE_W-1:0]                       lane_q, lane_d;
  logic                                    op_load_q, op_load_d;
  logic [ADDR_WIDTH-1:0]                   base_q, base_d;
  logic [vectorSize-1:0][registerSize-1:0] vect_q, vect_d;

  logic xfer, accept, complete, last_lane;

  assign xfer      = (state_q == S_XFER);
  // start is only honoured outside XFER (IDLE, or DONE for back-to-back).
  assign accept    = start & ~xfer;
  assign complete  = xfer & mem_ready;
  assign last_lane = (lane_q == LANE_W'(vectorSize - 1));

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    op_load_d = op_load_q;
    base_d    = base_q;
    vect_d    = vect_q;
    case (state_q)
      S_XFER: begin
        if (mem_ready) begin
          if (last_lane) state_d = S_DONE;
          else           lane_d  = lane_q + LANE_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d   = S_XFER;
      lane_d    = '0;
      op_load_d = op_load;
      base_d    = base_addr;
      vect_d    = vect_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      op_load_q <= 1'b0;
      base_q    <= '0;
      vect_q    <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      op_load_q <= op_load_d;
      base_q    <= base_d;
      vect_q    <= vect_d;
    end
  end

  // Memory port is a pure function of registered state, so it holds steady
  // while the memory stretches an access with mem_ready low.
  assign mem_req   = xfer;
  assign mem_we    = xfer & ~op_load_q;
  assign mem_addr  = xfer ? (base_q + ADDR_WIDTH'(lane_q)) : '0;
  assign mem_wdata = (xfer & ~op_load_q) ? vect_q[lane_q] : '0;
  assign done      = (state_q == S_DONE);
  assign stall     = xfer | accept;

  logic [registerSize-1:0] lane_out [vectorSize];

  for (genvar g = 0; g < vectorSize; g++) begin : g_lane
    vect_mem_lane #(.W(registerSize)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (complete & op_load_q & (lane_q == LANE_W'(g))),
      .wdata    (mem_rdata),
      .lane_out (lane_out[g])
    );
  end

  always_comb begin
    vect_out = '0;
    for (int i = 0; i < vectorSize; i++) vect_out[i] = lane_out[i];
  end
endmodule
